multi_ch_timer_ctrl: RTL and testbench
======================================

// Module: multi_ch_timer_ctrl
// PURPOSE
//  - Parametrised successor of the single-channel run/pause control FSM: NUM_CH independent timer channels.
//  - Each channel has an IDLE/RUNNING/PAUSED/DONE FSM, a CNT_W-bit up-counter and a programmable terminal limit.
//  - Channels run in one-shot or auto-reload mode.
//  - Sits between the front-panel/register decode (start/stop/clear pulses) and the display/interrupt logic.
// PARAMETERS
//  - NUM_CH  4   number of independent channels (1..16)
//  - CNT_W   16  counter and limit width per channel (2..32)
// PORTS
//  - clk          in   1           clock
//  - rst_n        in   1           asynchronous, active-low reset
//  - start        in   NUM_CH      per-channel start/resume request (level sampled each cycle)
//  - stop         in   NUM_CH      per-channel pause request
//  - clear        in   NUM_CH      per-channel return-to-IDLE request
//  - mode_reload  in   NUM_CH      1 = auto-reload at limit, 0 = one-shot; sampled with limit
//  - limit        in   NUM_CH*CNT_W  terminal count, channel i at [i*CNT_W +: CNT_W]
//  - enable       out  NUM_CH      1 while channel state == RUNNING
//  - status       out  NUM_CH*2    channel state code, channel i at [2*i +: 2]
//  - count        out  NUM_CH*CNT_W  current channel count
//  - expired      out  NUM_CH      one-cycle pulse per terminal-count event
//  - any_running  out  1           OR of enable
// BEHAVIOUR
//  - State codes: IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10, DONE=2'b11. All state, count and expired are registered.
//  - Reset: state=IDLE, count=0, expired=0, latched limit/mode=0. Hence enable=0, status=0, any_running=0.
//  - enable, status and any_running decode combinationally from the registered state.
//  - Request priority each cycle: clear > stop > start.
//  - IDLE: start -> RUNNING. Latch limit and mode_reload into the channel on that edge; count stays 0.
//  - RUNNING, normal cycle: count += 1 per clk edge.
//  - RUNNING, clear: -> IDLE, count=0.
//  - RUNNING, stop: -> PAUSED, count holds (no increment on that edge).
//  - RUNNING, count == latched limit (no clear/stop), one-shot: -> DONE, count holds at limit, expired=1 next cycle.
//  - RUNNING, count == latched limit (no clear/stop), reload: stay RUNNING, count=0, expired=1 next cycle.
//  - PAUSED: clear -> IDLE with count=0; start -> RUNNING with count held. Limit is not re-latched on resume.
//  - DONE: clear -> IDLE with count=0; start -> RUNNING with count=0, limit/mode re-latched.
//  - Limit 0: terminal on the first RUNNING cycle. One-shot then reaches DONE after 1 cycle; reload pulses expired every cycle.
//  - Counter never wraps silently: terminal compare precedes increment, so count <= limit always.
//  - Channels are fully independent; simultaneous requests on different channels are all honoured in the same cycle.
//  - Illegal/unused state cannot occur (2-bit code fully used); the default branch goes to IDLE.
//  - Async reset mid-count: immediate return to reset values; the first start after release behaves as from IDLE.
// CONFIGURATION
//  - Macro MULTI_CH_TIMER_CTRL_IRQ_EN.
//  - Defined: adds ports irq_mask (in, NUM_CH), irq_ack (in, NUM_CH, write-1-to-clear), irq_pending (out, NUM_CH) and irq (out, 1).
//    - irq_pending[i] sets on expired[i] and clears on irq_ack[i]; set wins over a same-cycle ack.
//    - irq = |(irq_pending & irq_mask), registered. Reset value 0.
//  - Undefined: those ports and registers do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package timer_ctrl_pkg: state localparams (IDLE/RUNNING/PAUSED/DONE) and the 2-bit state typedef/width constant.
//  - Sub-module timer_ch_fsm (CNT_W): one channel's FSM, counter, latched limit/mode and expired pulse.
//  - Top level instantiates NUM_CH copies in a generate loop, slices the buses, ORs any_running and holds the optional IRQ logic.
// TESTING
//  - NUM_CH=4, CNT_W=8.
//  - Reset: hold rst_n=0 with start=4'hF -> enable=0, status=0, count=0, expired=0. Release -> start acts on the next edge.
//  - One-shot: ch0 limit=5, mode=0, start 1 cycle -> count 0..5, status 11 after 6 RUNNING cycles, expired[0] single pulse, count holds 5.
//  - Reload: ch1 limit=3, mode=1 -> count 0,1,2,3,0,1...; expired[1] pulses every 4 cycles; status stays 01.
//  - Pause/resume: ch2 stop at count=7 -> status 10, count=7 for 10 cycles; start -> increments from 7. A new limit applied during pause is ignored.
//  - Priority: ch3 RUNNING with clear, stop and start high together -> IDLE, count=0. Stop+start in PAUSED -> stays PAUSED.
//  - IRQ (with macro): ch0 expire with mask=1 -> irq=1. Ack in the same cycle as a new expire -> pending stays 1. Lone ack -> irq=0.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared state encoding for the multi-channel timer controller.
// The 2-bit code is fully used, so every value is a legal channel state.
package timer_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        DONE    = 2'b11
    } state_t;

endpackage

// File: rtl/timer_ch_fsm.sv
// One timer channel: run/pause FSM, up-counter, latched limit/mode and expired pulse.
// Request priority is clear > stop > start in every state.
module timer_ch_fsm
    import timer_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             mode_reload,
    input  logic [CNT_W-1:0] limit,
    output state_t           state,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] lim_q;
    logic             mode_q;

    // Terminal compare is done before the increment, so count never exceeds lim_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            expired <= 1'b0;
            lim_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (!clear && !stop && start) begin
                        state  <= RUNNING;
                        lim_q  <= limit;
                        mode_q <= mode_reload;
                        count  <= '0;
                    end
                end
                RUNNING: begin
                    if (clear) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (stop) begin
                        state <= PAUSED;
                    end else if (count == lim_q) begin
                        expired <= 1'b1;
                        if (mode_q) begin
                            count <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                PAUSED: begin
                    if (clear) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (!stop && start) begin
                        state <= RUNNING;
                    end
                end
                DONE: begin
                    if (clear) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (!stop && start) begin
                        state  <= RUNNING;
                        count  <= '0;
                        lim_q  <= limit;
                        mode_q <= mode_reload;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_ch_timer_ctrl.sv
// NUM_CH independent timer channels with per-channel state/count buses.
// Optional interrupt logic is enabled with MULTI_CH_TIMER_CTRL_IRQ_EN.
module multi_ch_timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         stop,
    input  logic [NUM_CH-1:0]         clear,
    input  logic [NUM_CH-1:0]         mode_reload,
    input  logic [NUM_CH*CNT_W-1:0]   limit,
    output logic [NUM_CH-1:0]         enable,
    output logic [NUM_CH*STATE_W-1:0] status,
    output logic [NUM_CH*CNT_W-1:0]   count,
    output logic [NUM_CH-1:0]         expired,
    output logic                      any_running
`ifdef MULTI_CH_TIMER_CTRL_IRQ_EN
    ,
    input  logic [NUM_CH-1:0]         irq_mask,
    input  logic [NUM_CH-1:0]         irq_ack,
    output logic [NUM_CH-1:0]         irq_pending,
    output logic                      irq
`endif
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t ch_state;

        timer_ch_fsm #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start[i]),
            .stop        (stop[i]),
            .clear       (clear[i]),
            .mode_reload (mode_reload[i]),
            .limit       (limit[i*CNT_W +: CNT_W]),
            .state       (ch_state),
            .count       (count[i*CNT_W +: CNT_W]),
            .expired     (expired[i])
        );

        assign status[i*STATE_W +: STATE_W] = ch_state;
        assign enable[i] = (ch_state == RUNNING);
    end

    assign any_running = |enable;

`ifdef MULTI_CH_TIMER_CTRL_IRQ_EN
    // A fresh expire outranks a same-cycle acknowledge so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_pending <= '0;
            irq         <= 1'b0;
        end else begin
            irq_pending <= (irq_pending & ~irq_ack) | expired;
            irq         <= |(irq_pending & irq_mask);
        end
    end
`endif

endmodule

// File: tb/tb_multi_ch_timer_ctrl.sv
// Self-checking bench for multi_ch_timer_ctrl (NUM_CH=4, CNT_W=8); IRQ checks
// are compiled in when MULTI_CH_TIMER_CTRL_IRQ_EN is defined.
module tb_multi_ch_timer_ctrl;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start, stop, clear, mode_reload;
    logic [31:0] limit;
    logic [3:0]  enable;
    logic [7:0]  status;
    logic [31:0] count;
    logic [3:0]  expired;
    logic        any_running;
`ifdef MULTI_CH_TIMER_CTRL_IRQ_EN
    logic [3:0]  irq_mask, irq_ack, irq_pending;
    logic        irq;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    multi_ch_timer_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .mode_reload (mode_reload),
        .limit       (limit),
        .enable      (enable),
        .status      (status),
        .count       (count),
        .expired     (expired),
        .any_running (any_running)
`ifdef MULTI_CH_TIMER_CTRL_IRQ_EN
        ,
        .irq_mask    (irq_mask),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pending),
        .irq         (irq)
`endif
    );

    // Behavioural model: each channel is a state number, a count and a latched limit.
    int m_st[4], m_cnt[4], m_lim[4];
    bit m_md[4], m_exp[4];
    int n_st, n_cnt, n_lim;
    bit n_md, n_exp;
`ifdef MULTI_CH_TIMER_CTRL_IRQ_EN
    logic [3:0] m_pend;
    logic       m_irq;
`endif

    function automatic void ch_next(input int st, input int cnt, input int lim, input bit md,
                                    input bit s, input bit p, input bit c,
                                    input int new_lim, input bit new_md,
                                    output int nst, output int ncnt, output int nlim,
                                    output bit nmd, output bit nexp);
        nst = st; ncnt = cnt; nlim = lim; nmd = md; nexp = 1'b0;
        if (c) begin
            nst = M_IDLE;
            ncnt = 0;
        end else if (p) begin
            if (st == M_RUN) nst = M_PAUSE;
        end else if (st == M_RUN) begin
            if (cnt == lim) begin
                nexp = 1'b1;
                if (md) ncnt = 0;
                else nst = M_DONE;
            end else begin
                ncnt = cnt + 1;
            end
        end else if (s) begin
            nst = M_RUN;
            if (st != M_PAUSE) begin
                ncnt = 0;
                nlim = new_lim;
                nmd = new_md;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_st[i] <= M_IDLE; m_cnt[i] <= 0; m_lim[i] <= 0;
                m_md[i] <= 1'b0; m_exp[i] <= 1'b0;
            end
`ifdef MULTI_CH_TIMER_CTRL_IRQ_EN
            m_pend <= '0;
            m_irq  <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                ch_next(m_st[i], m_cnt[i], m_lim[i], m_md[i], start[i], stop[i], clear[i],
                        int'(limit[8*i +: 8]), mode_reload[i], n_st, n_cnt, n_lim, n_md, n_exp);
                m_st[i] <= n_st; m_cnt[i] <= n_cnt; m_lim[i] <= n_lim;
                m_md[i] <= n_md; m_exp[i] <= n_exp;
            end
`ifdef MULTI_CH_TIMER_CTRL_IRQ_EN
            m_pend <= (m_pend & ~irq_ack) | {m_exp[3], m_exp[2], m_exp[1], m_exp[0]};
            m_irq  <= |(m_pend & irq_mask);
`endif
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    endtask

    logic [7:0]  e_status;
    logic [31:0] e_count;
    logic [3:0]  e_exp, e_en;

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                e_status[2*i +: 2] = 2'(m_st[i]);
                e_count[8*i +: 8]  = 8'(m_cnt[i]);
                e_exp[i]           = m_exp[i];
                e_en[i]            = (m_st[i] == M_RUN);
            end
            checkOutput("status", 64'(status), 64'(e_status));
            checkOutput("count", 64'(count), 64'(e_count));
            checkOutput("expired", 64'(expired), 64'(e_exp));
            checkOutput("enable", 64'(enable), 64'(e_en));
            checkOutput("any_running", 64'(any_running), 64'(|e_en));
`ifdef MULTI_CH_TIMER_CTRL_IRQ_EN
            checkOutput("irq_pending", 64'(irq_pending), 64'(m_pend));
            checkOutput("irq", 64'(irq), 64'(m_irq));
`endif
        end
    end

    task automatic applyStimulus(input logic [3:0] s, input logic [3:0] p, input logic [3:0] c, input int n);
        start = s;
        stop  = p;
        clear = c;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 4'hF; stop = 4'h0; clear = 4'h0;
        mode_reload = 4'h0; limit = 32'h0;
`ifdef MULTI_CH_TIMER_CTRL_IRQ_EN
        irq_mask = 4'h0; irq_ack = 4'h0;
`endif
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("rst_status", 64'(status), 64'h0);
        checkOutput("rst_count", 64'(count), 64'h0);
        checkOutput("rst_enable", 64'(enable), 64'h0);
        checkOutput("rst_expired", 64'(expired), 64'h0);

        // One-shot, ch0 limit 5
        limit[7:0] = 8'd5;
        rst_n = 1'b1;
        applyStimulus(4'b0001, 4'b0, 4'b0, 1);
        checkOutput("os_start_status", 64'(status), 64'h01);
        checkOutput("os_start_enable", 64'(enable), 64'h1);
        checkOutput("os_start_count", 64'(count), 64'h0);
        applyStimulus(4'b0, 4'b0, 4'b0, 5);
        checkOutput("os_cnt5", 64'(count), 64'h5);
        checkOutput("os_run5_status", 64'(status), 64'h01);
        applyStimulus(4'b0, 4'b0, 4'b0, 1);
        checkOutput("os_done_status", 64'(status), 64'h03);
        checkOutput("os_done_expired", 64'(expired), 64'h1);
        checkOutput("os_model_st", 64'(m_st[0]), 64'(M_DONE));
        applyStimulus(4'b0, 4'b0, 4'b0, 1);
        checkOutput("os_hold_count", 64'(count), 64'h5);
        checkOutput("os_pulse_end", 64'(expired), 64'h0);

        // Auto-reload, ch1 limit 3
        limit[15:8] = 8'd3; mode_reload[1] = 1'b1;
        applyStimulus(4'b0010, 4'b0, 4'b0, 1);
        checkOutput("rl_status", 64'(status), 64'h07);
        applyStimulus(4'b0, 4'b0, 4'b0, 4);
        checkOutput("rl_wrap_count", 64'(count[15:8]), 64'h0);
        checkOutput("rl_expired", 64'(expired), 64'h2);
        applyStimulus(4'b0, 4'b0, 4'b0, 3);
        checkOutput("rl_count3", 64'(count[15:8]), 64'h3);
        checkOutput("rl_still_run", 64'(status[3:2]), 64'h1);

        // Pause/resume, ch2 limit 20; a new limit during pause must be ignored
        limit[23:16] = 8'd20;
        applyStimulus(4'b0100, 4'b0, 4'b0, 1);
        applyStimulus(4'b0, 4'b0, 4'b0, 7);
        checkOutput("pr_count7", 64'(count[23:16]), 64'h7);
        limit[23:16] = 8'd9;
        applyStimulus(4'b0, 4'b0100, 4'b0, 1);
        checkOutput("pr_paused", 64'(status[5:4]), 64'h2);
        applyStimulus(4'b0, 4'b0, 4'b0, 10);
        checkOutput("pr_hold_count", 64'(count[23:16]), 64'h7);
        checkOutput("pr_hold_status", 64'(status[5:4]), 64'h2);
        applyStimulus(4'b0100, 4'b0, 4'b0, 1);
        checkOutput("pr_resume_count", 64'(count[23:16]), 64'h7);
        checkOutput("pr_resume_status", 64'(status[5:4]), 64'h1);
        applyStimulus(4'b0, 4'b0, 4'b0, 5);
        checkOutput("pr_past_new_limit", 64'(count[23:16]), 64'd12);
        checkOutput("pr_model_lim", 64'(m_lim[2]), 64'd20);
        applyStimulus(4'b0, 4'b0, 4'b0, 9);
        checkOutput("pr_done", 64'(status[5:4]), 64'h3);
        checkOutput("pr_expired", 64'(expired[2]), 64'h1);
        checkOutput("pr_done_count", 64'(count[23:16]), 64'd20);

        // Priority, ch3
        limit[31:24] = 8'd100;
        applyStimulus(4'b1000, 4'b0, 4'b0, 1);
        applyStimulus(4'b0, 4'b0, 4'b0, 3);
        checkOutput("pri_count3", 64'(count[31:24]), 64'h3);
        applyStimulus(4'b1000, 4'b1000, 4'b1000, 1);
        checkOutput("pri_clear_status", 64'(status[7:6]), 64'h0);
        checkOutput("pri_clear_count", 64'(count[31:24]), 64'h0);
        applyStimulus(4'b1000, 4'b0, 4'b0, 1);
        applyStimulus(4'b0, 4'b0, 4'b0, 2);
        applyStimulus(4'b0, 4'b1000, 4'b0, 1);
        applyStimulus(4'b1000, 4'b1000, 4'b0, 1);
        checkOutput("pri_stop_over_start", 64'(status[7:6]), 64'h2);
        checkOutput("pri_paused_count", 64'(count[31:24]), 64'h2);
        applyStimulus(4'b0, 4'b0, 4'b1000, 1);
        checkOutput("pri_idle", 64'(status[7:6]), 64'h0);

        // Limit 0: one-shot from DONE on ch0, reload on ch1
        limit[7:0] = 8'd0; mode_reload[0] = 1'b0;
        applyStimulus(4'b0001, 4'b0, 4'b0, 1);
        checkOutput("l0_os_run", 64'(status[1:0]), 64'h1);
        applyStimulus(4'b0, 4'b0, 4'b0, 1);
        checkOutput("l0_os_done", 64'(status[1:0]), 64'h3);
        checkOutput("l0_os_exp", 64'(expired[0]), 64'h1);
        applyStimulus(4'b0, 4'b0, 4'b0010, 1);
        limit[15:8] = 8'd0;
        applyStimulus(4'b0010, 4'b0, 4'b0, 1);
        applyStimulus(4'b0, 4'b0, 4'b0, 2);
        checkOutput("l0_rl_exp_a", 64'(expired[1]), 64'h1);
        checkOutput("l0_rl_count", 64'(count[15:8]), 64'h0);
        applyStimulus(4'b0, 4'b0, 4'b0, 1);
        checkOutput("l0_rl_exp_b", 64'(expired[1]), 64'h1);

        // All channels started together
        applyStimulus(4'b0, 4'b0, 4'hF, 1);
        limit = {8'd4, 8'd3, 8'd2, 8'd1};
        mode_reload = 4'b0101;
        applyStimulus(4'hF, 4'b0, 4'b0, 1);
        checkOutput("sim_all_run", 64'(status), 64'h55);
        applyStimulus(4'b0, 4'b0, 4'b0, 12);

        // Asynchronous reset mid-count
        applyStimulus(4'b0, 4'b0, 4'hF, 1);
        limit = {4{8'd50}};
        mode_reload = 4'b0;
        applyStimulus(4'hF, 4'b0, 4'b0, 1);
        applyStimulus(4'b0, 4'b0, 4'b0, 3);
        checkOutput("ar_pre_count", 64'(count), 64'h03030303);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("ar_count", 64'(count), 64'h0);
        checkOutput("ar_status", 64'(status), 64'h0);
        checkOutput("ar_any_running", 64'(any_running), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(4'b0001, 4'b0, 4'b0, 1);
        checkOutput("ar_restart_status", 64'(status), 64'h01);
        applyStimulus(4'b0, 4'b0, 4'b0, 2);
        checkOutput("ar_restart_count", 64'(count[7:0]), 64'h2);

`ifdef MULTI_CH_TIMER_CTRL_IRQ_EN
        // ch0 reload limit 2: expired after edges 3, 6, 9 relative to the start edge
        applyStimulus(4'b0, 4'b0, 4'hF, 1);
        applyStimulus(4'b0, 4'b0, 4'b0, 1);
        irq_ack = 4'hF;
        applyStimulus(4'b0, 4'b0, 4'b0, 2);
        irq_ack = 4'h0;
        limit[7:0] = 8'd2; mode_reload[0] = 1'b1; irq_mask = 4'b0001;
        applyStimulus(4'b0001, 4'b0, 4'b0, 1);
        applyStimulus(4'b0, 4'b0, 4'b0, 4);
        checkOutput("irq_pend_set", 64'(irq_pending), 64'h1);
        applyStimulus(4'b0, 4'b0, 4'b0, 1);
        checkOutput("irq_raised", 64'(irq), 64'h1);
        applyStimulus(4'b0, 4'b0, 4'b0, 1);
        irq_ack = 4'b0001;
        applyStimulus(4'b0, 4'b0, 4'b0, 1);
        checkOutput("irq_set_wins", 64'(irq_pending), 64'h1);
        irq_ack = 4'b0;
        applyStimulus(4'b0, 4'b0, 4'b0001, 1);
        irq_ack = 4'b0001;
        applyStimulus(4'b0, 4'b0, 4'b0, 1);
        checkOutput("irq_ack_clears", 64'(irq_pending), 64'h0);
        irq_ack = 4'b0;
        applyStimulus(4'b0, 4'b0, 4'b0, 1);
        checkOutput("irq_low", 64'(irq), 64'h0);
`endif

        applyStimulus(4'b0, 4'b0, 4'b0, 2);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
